multiport_ib_fifo: RTL and testbench

- Parametrised multi-write/multi-read instruction buffer FIFO. It is the next-generation IFU instruction buffer, sitting between fetch/predecode and decode.
- Adds over the previous buffer:
  - all-or-nothing write acceptance with overflow detection
  - read-count clamping with underflow detection
  - youngest-entry truncation for intra-block redirects
  - almost-full threshold
  - zeroed invalid output lanes
- Register-based storage with zero-latency first-word-fall-through read.

---
 rtl/multiport_ib_fifo.sv | 107 ++++++++++
 tb/tb_multiport_ib_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multiport_ib_fifo.sv
// multiport_ib_fifo: multi-write/multi-read instruction buffer FIFO with
// first-word-fall-through read, all-or-nothing writes and youngest-entry truncation.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   Flush              synchronous clear of pointers and error flags
//   DataIn/WriteEnable write lanes; enabled lanes packed in ascending order
//   ReadEnableCnt      entries consumed this cycle (clamped to UsedCnt)
//   Truncate/Cnt       drop the youngest entries, blocking writes that cycle
//   DataOut/Mask       oldest READ_PORTS entries, invalid lanes zeroed
//   UsedCnt/FreeCnt    occupancy, AlmostFull at UsedCnt >= AF_THRESH
//   Overflow/UnderflowErr sticky error flags
module multiport_ib_fifo #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 16,
    parameter int WRITE_PORTS = 4,
    parameter int READ_PORTS  = 2,
    parameter int AF_THRESH   = DEPTH - WRITE_PORTS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              Flush,
    input  logic [WRITE_PORTS*WIDTH-1:0]      DataIn,
    input  logic [WRITE_PORTS-1:0]            WriteEnable,
    input  logic [$clog2(READ_PORTS):0]       ReadEnableCnt,
    input  logic                              Truncate,
    input  logic [$clog2(DEPTH):0]            TruncateCnt,
    output logic [READ_PORTS*WIDTH-1:0]       DataOut,
    output logic [READ_PORTS-1:0]             OutputValidMask,
    output logic [$clog2(DEPTH):0]            UsedCnt,
    output logic [$clog2(DEPTH):0]            FreeCnt,
    output logic                              AlmostFull,
    output logic                              OverflowErr,
    output logic                              UnderflowErr
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF = PW'(AF_THRESH);

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    off [WRITE_PORTS];
    logic [PW-1:0]    used, free, rd_req, rd_eff, rem, tr, wr_cnt;
    logic             under, wr_fit, wr_ok;

    assign used         = wr_ptr_q - rd_ptr_q;
    assign free         = PW'(DEPTH) - used;
    assign UsedCnt      = used;
    assign FreeCnt      = free;
    assign AlmostFull   = used >= AF;
    assign OverflowErr  = ovf_q;
    assign UnderflowErr = udf_q;

    // Prefix count of enabled lanes gives each lane its compacted slot.
    always_comb begin
        wr_cnt = '0;
        for (int i = 0; i < WRITE_PORTS; i++) begin
            off[i] = wr_cnt;
            wr_cnt = wr_cnt + PW'(WriteEnable[i]);
        end
    end

    always_comb begin
        for (int v = 0; v < READ_PORTS; v++) begin
            OutputValidMask[v]          = PW'(v) < used;
            DataOut[v*WIDTH +: WIDTH]   = OutputValidMask[v] ? mem_q[AW'(rd_ptr_q + PW'(v))] : '0;
        end
    end

    always_comb begin
        rd_req   = PW'(ReadEnableCnt);
        under    = rd_req > used;
        rd_eff   = under ? used : rd_req;
        rem      = used - rd_eff;
        tr       = TruncateCnt > rem ? rem : TruncateCnt;
        // Fit is judged against pre-edge free space; same-cycle reads give no credit.
        wr_fit   = wr_cnt <= free;
        wr_ok    = !Flush && !Truncate && wr_fit;
        rd_ptr_d = Flush ? '0 : rd_ptr_q + rd_eff;
        wr_ptr_d = Flush ? '0 : Truncate ? wr_ptr_q - tr : wr_fit ? wr_ptr_q + wr_cnt : wr_ptr_q;
        ovf_d    = !Flush && (ovf_q || (!Truncate && !wr_fit));
        udf_d    = !Flush && (udf_q || under);
        mem_d    = mem_q;
        for (int i = 0; i < WRITE_PORTS; i++)
            if (wr_ok && WriteEnable[i])
                mem_d[AW'(wr_ptr_q + off[i])] = DataIn[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_multiport_ib_fifo.sv
// tb_multiport_ib_fifo: directed self-checking bench for multiport_ib_fifo (DEPTH=8).
module tb_multiport_ib_fifo;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         Flush;
    logic [127:0] DataIn;
    logic [3:0]   WriteEnable;
    logic [1:0]   ReadEnableCnt;
    logic         Truncate;
    logic [3:0]   TruncateCnt;
    logic [63:0]  DataOut;
    logic [1:0]   OutputValidMask;
    logic [3:0]   UsedCnt;
    logic [3:0]   FreeCnt;
    logic         AlmostFull;
    logic         OverflowErr;
    logic         UnderflowErr;
    int           checks = 0;
    int           errors = 0;

    multiport_ib_fifo #(.WIDTH(32), .DEPTH(8), .WRITE_PORTS(4), .READ_PORTS(2), .AF_THRESH(6)) dut (
        .clk(clk), .rst_n(rst_n), .Flush(Flush), .DataIn(DataIn), .WriteEnable(WriteEnable),
        .ReadEnableCnt(ReadEnableCnt), .Truncate(Truncate), .TruncateCnt(TruncateCnt),
        .DataOut(DataOut), .OutputValidMask(OutputValidMask), .UsedCnt(UsedCnt), .FreeCnt(FreeCnt),
        .AlmostFull(AlmostFull), .OverflowErr(OverflowErr), .UnderflowErr(UnderflowErr)
    );

    always #5 clk = ~clk;

    task automatic idle();
        Flush = 0; DataIn = '0; WriteEnable = '0; ReadEnableCnt = '0; Truncate = 0; TruncateCnt = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic flush();
        Flush = 1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        tick();
        checks++; if (UsedCnt !== 4'd0) begin errors++; $display("FAIL reset_used: got %0d expected 0", UsedCnt); end
        checks++; if (FreeCnt !== 4'd8) begin errors++; $display("FAIL reset_free: got %0d expected 8", FreeCnt); end
        checks++; if (OutputValidMask !== 2'b00) begin errors++; $display("FAIL reset_mask: got %b expected 00", OutputValidMask); end
        checks++; if (DataOut !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", DataOut); end
        checks++; if (AlmostFull !== 1'b0) begin errors++; $display("FAIL reset_af: got %b expected 0", AlmostFull); end
        checks++; if ({OverflowErr, UnderflowErr} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {OverflowErr, UnderflowErr}); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_sparse_write();
        flush();
        WriteEnable = 4'b1010;
        DataIn = {32'hB, 32'h0, 32'hA, 32'h0};
        tick();
        checks++; if (UsedCnt !== 4'd2) begin errors++; $display("FAIL sparse_used: got %0d expected 2", UsedCnt); end
        checks++; if (OutputValidMask !== 2'b11) begin errors++; $display("FAIL sparse_mask: got %b expected 11", OutputValidMask); end
        checks++; if (DataOut !== {32'hB, 32'hA}) begin errors++; $display("FAIL sparse_data: got %h expected 0000000b0000000a", DataOut); end
        checks++; if (FreeCnt !== 4'd6) begin errors++; $display("FAIL sparse_free: got %0d expected 6", FreeCnt); end
        checks++; if (AlmostFull !== 1'b0) begin errors++; $display("FAIL sparse_af: got %b expected 0", AlmostFull); end
    endtask

    task automatic test_fill_overflow();
        flush();
        WriteEnable = 4'b1111; DataIn = {32'd4, 32'd3, 32'd2, 32'd1};
        tick();
        WriteEnable = 4'b1111; DataIn = {32'd8, 32'd7, 32'd6, 32'd5};
        tick();
        checks++; if (UsedCnt !== 4'd8) begin errors++; $display("FAIL fill_used: got %0d expected 8", UsedCnt); end
        checks++; if (FreeCnt !== 4'd0) begin errors++; $display("FAIL fill_free: got %0d expected 0", FreeCnt); end
        checks++; if (AlmostFull !== 1'b1) begin errors++; $display("FAIL fill_af: got %b expected 1", AlmostFull); end
        checks++; if (DataOut !== {32'd2, 32'd1}) begin errors++; $display("FAIL fill_data: got %h expected 0000000200000001", DataOut); end
        checks++; if (OverflowErr !== 1'b0) begin errors++; $display("FAIL fill_ovf_clear: got %b expected 0", OverflowErr); end
        WriteEnable = 4'b0001; DataIn = {96'h0, 32'h55}; ReadEnableCnt = 2'd1;
        tick();
        checks++; if (OverflowErr !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", OverflowErr); end
        checks++; if (UsedCnt !== 4'd7) begin errors++; $display("FAIL ovf_used: got %0d expected 7", UsedCnt); end
        checks++; if (DataOut !== {32'd3, 32'd2}) begin errors++; $display("FAIL ovf_data: got %h expected 0000000300000002", DataOut); end
        tick();
        checks++; if (OverflowErr !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", OverflowErr); end
        flush();
        checks++; if (OverflowErr !== 1'b0) begin errors++; $display("FAIL ovf_flush: got %b expected 0", OverflowErr); end
        checks++; if (UsedCnt !== 4'd0) begin errors++; $display("FAIL ovf_flush_used: got %0d expected 0", UsedCnt); end
    endtask

    task automatic test_underflow();
        flush();
        WriteEnable = 4'b0001; DataIn = {96'h0, 32'h11};
        tick();
        ReadEnableCnt = 2'd2;
        tick();
        checks++; if (UsedCnt !== 4'd0) begin errors++; $display("FAIL udf_used: got %0d expected 0", UsedCnt); end
        checks++; if (UnderflowErr !== 1'b1) begin errors++; $display("FAIL udf_flag: got %b expected 1", UnderflowErr); end
        checks++; if (OutputValidMask !== 2'b00) begin errors++; $display("FAIL udf_mask: got %b expected 00", OutputValidMask); end
        checks++; if (DataOut !== 64'h0) begin errors++; $display("FAIL udf_data: got %h expected 0", DataOut); end
        WriteEnable = 4'b0001; DataIn = {96'h0, 32'h22}; ReadEnableCnt = 2'd1;
        tick();
        checks++; if (UsedCnt !== 4'd1) begin errors++; $display("FAIL empty_rw_used: got %0d expected 1", UsedCnt); end
        checks++; if (DataOut !== {32'h0, 32'h22}) begin errors++; $display("FAIL empty_rw_data: got %h expected 0000000000000022", DataOut); end
        checks++; if (OverflowErr !== 1'b0) begin errors++; $display("FAIL empty_rw_ovf: got %b expected 0", OverflowErr); end
        flush();
        checks++; if (UnderflowErr !== 1'b0) begin errors++; $display("FAIL udf_flush: got %b expected 0", UnderflowErr); end
    endtask

    task automatic test_wrap();
        flush();
        for (int c = 0; c < 20; c++) begin
            WriteEnable = 4'b0011;
            DataIn = {64'h0, 32'(2 * c + 1), 32'(2 * c)};
            ReadEnableCnt = (c > 0) ? 2'd2 : 2'd0;
            tick();
            checks++; if (DataOut !== {32'(2 * c + 1), 32'(2 * c)}) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected lanes %0d,%0d", c, DataOut, 2 * c + 1, 2 * c); end
            checks++; if (UsedCnt !== 4'd2) begin errors++; $display("FAIL wrap_used[%0d]: got %0d expected 2", c, UsedCnt); end
            checks++; if ({OverflowErr, UnderflowErr} !== 2'b00) begin errors++; $display("FAIL wrap_err[%0d]: got %b expected 00", c, {OverflowErr, UnderflowErr}); end
        end
    endtask

    task automatic test_truncate();
        flush();
        WriteEnable = 4'b1111; DataIn = {32'd4, 32'd3, 32'd2, 32'd1};
        tick();
        WriteEnable = 4'b0001; DataIn = {96'h0, 32'd5};
        tick();
        checks++; if (UsedCnt !== 4'd5) begin errors++; $display("FAIL trunc_setup: got %0d expected 5", UsedCnt); end
        ReadEnableCnt = 2'd1; Truncate = 1; TruncateCnt = 4'd3;
        WriteEnable = 4'b0001; DataIn = {96'h0, 32'h99};
        tick();
        checks++; if (UsedCnt !== 4'd1) begin errors++; $display("FAIL trunc_used: got %0d expected 1", UsedCnt); end
        checks++; if (DataOut !== {32'h0, 32'd2}) begin errors++; $display("FAIL trunc_data: got %h expected 0000000000000002", DataOut); end
        checks++; if (OutputValidMask !== 2'b01) begin errors++; $display("FAIL trunc_mask: got %b expected 01", OutputValidMask); end
        checks++; if ({OverflowErr, UnderflowErr} !== 2'b00) begin errors++; $display("FAIL trunc_err: got %b expected 00", {OverflowErr, UnderflowErr}); end
        Truncate = 1; TruncateCnt = 4'd7;
        tick();
        checks++; if (UsedCnt !== 4'd0) begin errors++; $display("FAIL trunc_over_used: got %0d expected 0", UsedCnt); end
        checks++; if ({OverflowErr, UnderflowErr} !== 2'b00) begin errors++; $display("FAIL trunc_over_err: got %b expected 00", {OverflowErr, UnderflowErr}); end
        Truncate = 1; TruncateCnt = 4'd0; WriteEnable = 4'b0011; DataIn = {64'h0, 32'h2, 32'h1};
        tick();
        checks++; if (UsedCnt !== 4'd0) begin errors++; $display("FAIL trunc_zero_block: got %0d expected 0", UsedCnt); end
    endtask

    task automatic test_async_reset();
        flush();
        WriteEnable = 4'b1111; DataIn = {32'd4, 32'd3, 32'd2, 32'd1};
        tick();
        WriteEnable = 4'b0001; DataIn = {96'h0, 32'd5};
        tick();
        checks++; if (UsedCnt !== 4'd5) begin errors++; $display("FAIL arst_setup: got %0d expected 5", UsedCnt); end
        #2 rst_n = 0;
        #1;
        checks++; if (UsedCnt !== 4'd0) begin errors++; $display("FAIL arst_used: got %0d expected 0", UsedCnt); end
        checks++; if (FreeCnt !== 4'd8) begin errors++; $display("FAIL arst_free: got %0d expected 8", FreeCnt); end
        checks++; if (DataOut !== 64'h0) begin errors++; $display("FAIL arst_data: got %h expected 0", DataOut); end
        rst_n = 1;
        WriteEnable = 4'b0001; DataIn = {96'h0, 32'h77};
        tick();
        checks++; if (DataOut !== {32'h0, 32'h77}) begin errors++; $display("FAIL arst_write: got %h expected 0000000000000077", DataOut); end
        checks++; if (UsedCnt !== 4'd1) begin errors++; $display("FAIL arst_write_used: got %0d expected 1", UsedCnt); end
    endtask

    initial begin
        idle();
        test_reset();
        test_sparse_write();
        test_fill_overflow();
        test_underflow();
        test_wrap();
        test_truncate();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
